host_word_sender: RTL and testbench



---
 rtl/host_word_sender.sv | 162 ++++++++++++++++
 tb/tb_host_word_sender.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_word_sender.sv
// Host-side secret-word transmitter.
// Latches the 5-character word from the host message register when rec_ready
// rises, rejects words that still contain the blank character (BLANK_CHR), and
// otherwise streams SOF, the characters (first-entered first), an XOR checksum
// and EOF over a valid/ready byte interface toward the host UART TX.
module host_word_sender #(
  parameter int          NUM_CHARS = 5,
  parameter logic [7:0]  SOF_BYTE  = 8'h02,
  parameter logic [7:0]  EOF_BYTE  = 8'h03,
  parameter logic [7:0]  BLANK_CHR = 8'h5F
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   rec_ready,
  input  logic [NUM_CHARS*8-1:0] temp_word,
  input  logic                   gameEnd_host,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   send_done,
  output logic                   word_err
);

  localparam int WORD_W = NUM_CHARS * 8;
  localparam int IDX_W  = $clog2(NUM_CHARS + 3);

  // Frame positions: 0 = SOF, 1..NUM_CHARS = chars, then checksum, then EOF.
  localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(NUM_CHARS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_recReadyQ;
  logic [WORD_W-1:0] r_word;
  logic [7:0]        r_chk;
  logic [IDX_W-1:0]  r_idx;

  logic              w_rise;
  logic              w_anyBlank;
  logic [7:0]        w_chk;
  logic [IDX_W-1:0]  w_nextIdx;
  logic [7:0]        w_nextByte;

  // Byte k of a word counted from the least significant end.
  function automatic logic [7:0] getByte(input logic [WORD_W-1:0] word, input int k);
    logic [WORD_W-1:0] shifted;
    shifted = word >> (8 * k);
    return shifted[7:0];
  endfunction

  assign w_rise = rec_ready & ~r_recReadyQ;

  // Checksum and blank detection on the incoming word, used at latch time.
  always_comb begin
    w_chk      = 8'h00;
    w_anyBlank = 1'b0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      w_chk = w_chk ^ getByte(temp_word, k);
      if (getByte(temp_word, k) == BLANK_CHR) begin
        w_anyBlank = 1'b1;
      end
    end
  end

  // Byte that follows the one currently offered, taken from the latched word.
  always_comb begin
    w_nextIdx = r_idx + IDX_W'(1);
    if (w_nextIdx == '0) begin
      w_nextByte = SOF_BYTE;
    end else if (w_nextIdx == CHK_IDX) begin
      w_nextByte = r_chk;
    end else if (w_nextIdx == LAST_IDX) begin
      w_nextByte = EOF_BYTE;
    end else begin
      w_nextByte = getByte(r_word, NUM_CHARS - int'(w_nextIdx));
    end
  end

  // Frame sequencer with registered outputs; gameEnd_host overrides everything.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= IDLE;
      r_recReadyQ <= 1'b0;
      r_word      <= '0;
      r_chk       <= 8'h00;
      r_idx       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      send_done   <= 1'b0;
      word_err    <= 1'b0;
    end else begin
      r_recReadyQ <= rec_ready;
      if (gameEnd_host) begin
        r_state   <= IDLE;
        r_idx     <= '0;
        tx_valid  <= 1'b0;
        busy      <= 1'b0;
        send_done <= 1'b0;
        word_err  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            send_done <= 1'b0;
            if (w_rise) begin
              r_word <= temp_word;
              r_chk  <= w_chk;
              r_idx  <= '0;
              if (w_anyBlank) begin
                r_state  <= ERR;
                word_err <= 1'b1;
              end else begin
                r_state  <= SEND;
                tx_valid <= 1'b1;
                tx_data  <= SOF_BYTE;
                busy     <= 1'b1;
              end
            end
          end
          SEND: begin
            if (tx_ready) begin
              if (r_idx == LAST_IDX) begin
                r_state   <= DONE;
                r_idx     <= '0;
                tx_valid  <= 1'b0;
                tx_data   <= 8'h00;
                busy      <= 1'b0;
                send_done <= 1'b1;
              end else begin
                r_idx   <= w_nextIdx;
                tx_data <= w_nextByte;
              end
            end
          end
          DONE: begin
            send_done <= 1'b0;
            if (!rec_ready) begin
              r_state <= IDLE;
            end
          end
          ERR: begin
            if (!rec_ready) begin
              r_state  <= IDLE;
              word_err <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_word_sender.sv
// Bench for host_word_sender: framing, back-pressure, blank-word rejection,
// abort, hold/no-resend, word latching and asynchronous reset.
module tb_host_word_sender;

  logic        clk;
  logic        nRst;
  logic        rec_ready;
  logic [39:0] temp_word;
  logic        gameEnd_host;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        send_done;
  logic        word_err;

  int nChecks = 0;
  int nFails  = 0;

  logic [7:0] expQ[$];
  logic [7:0] obsQ[$];
  int validCycles;
  int doneCount;
  int heldBad;
  int busyBad;

  localparam logic [39:0] HELLO = 40'h48_45_4C_4C_4F;
  localparam logic [39:0] HEBLO = 40'h48_45_5F_4C_4F;
  localparam logic [39:0] WORDS = 40'h57_4F_52_44_53;

  host_word_sender dut (
    .clk          (clk),
    .nRst         (nRst),
    .rec_ready    (rec_ready),
    .temp_word    (temp_word),
    .gameEnd_host (gameEnd_host),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .busy         (busy),
    .send_done    (send_done),
    .word_err     (word_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] modelChk(input logic [39:0] w);
    return w[39:32] ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic pushFrame(input logic [39:0] w, input logic [7:0] c);
    expQ.push_back(8'h02);
    expQ.push_back(w[39:32]);
    expQ.push_back(w[31:24]);
    expQ.push_back(w[23:16]);
    expQ.push_back(w[15:8]);
    expQ.push_back(w[7:0]);
    expQ.push_back(c);
    expQ.push_back(8'h03);
  endtask

  task automatic releaseRec();
    rec_ready = 1'b0;
    tick();
    tick();
  endtask

  // Runs the byte sink for a fixed window, recording accepted bytes.
  task automatic captureFrame(input int stallIdx, input int stallLen, input bit doChange,
                              input logic [39:0] newWord, input int maxCycles);
    int accepted;
    int stallCnt;
    logic [7:0] heldVal;
    accepted = 0;
    stallCnt = 0;
    heldVal = 8'h00;
    validCycles = 0;
    doneCount = 0;
    heldBad = 0;
    busyBad = 0;
    obsQ.delete();
    for (int c = 0; c < maxCycles; c++) begin
      tick();
      if (send_done === 1'b1) doneCount++;
      if (tx_valid === 1'b1) begin
        validCycles++;
        if (busy !== 1'b1) busyBad++;
        if (stallCnt > 0 && accepted == stallIdx && tx_data !== heldVal) heldBad++;
        if (accepted == stallIdx && stallCnt < stallLen) begin
          heldVal = tx_data;
          stallCnt++;
          tx_ready = 1'b0;
        end else begin
          tx_ready = 1'b1;
          obsQ.push_back(tx_data);
          accepted++;
          if (doChange && accepted == 3) temp_word = newWord;
        end
      end else begin
        tx_ready = 1'b1;
      end
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    rec_ready = 1'b0;
    gameEnd_host = 1'b0;
    tx_ready = 1'b0;
    temp_word = '0;
    #12;
    nChecks++;
    if ({tx_valid, tx_data, busy, send_done, word_err} !== 12'h000) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h busy=%b done=%b err=%b, need all 0",
               tx_valid, tx_data, busy, send_done, word_err);
    end
    @(negedge clk);
    nRst = 1'b1;
    tx_ready = 1'b1;
    tick();
  endtask

  task automatic test_hello();
    logic [7:0] e;
    logic [7:0] o;
    temp_word = HELLO;
    pushFrame(HELLO, 8'h42);
    rec_ready = 1'b1;
    captureFrame(99, 0, 1'b0, '0, 16);
    nChecks++;
    if (validCycles != 8) begin
      nFails++;
      $display("[TB] FAIL hello_valid_cycles: got %0d, need 8", validCycles);
    end
    nChecks++;
    if (doneCount != 1) begin
      nFails++;
      $display("[TB] FAIL hello_send_done: got %0d pulses, need 1", doneCount);
    end
    nChecks++;
    if (busyBad != 0) begin
      nFails++;
      $display("[TB] FAIL hello_busy: busy low on %0d valid cycles, need 0", busyBad);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 8'hXX;
      nChecks++;
      if (o !== e) begin
        nFails++;
        $display("[TB] FAIL hello_byte: got %h, need %h", o, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e;
    logic [7:0] o;
    temp_word = HELLO;
    pushFrame(HELLO, 8'h42);
    rec_ready = 1'b1;
    captureFrame(2, 3, 1'b0, '0, 16);
    nChecks++;
    if (validCycles != 11) begin
      nFails++;
      $display("[TB] FAIL stall_valid_cycles: got %0d, need 11", validCycles);
    end
    nChecks++;
    if (heldBad != 0) begin
      nFails++;
      $display("[TB] FAIL stall_hold: data changed %0d times while stalled, need 0", heldBad);
    end
    nChecks++;
    if (doneCount != 1) begin
      nFails++;
      $display("[TB] FAIL stall_send_done: got %0d pulses, need 1", doneCount);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 8'hXX;
      nChecks++;
      if (o !== e) begin
        nFails++;
        $display("[TB] FAIL stall_byte: got %h, need %h", o, e);
      end
    end
  endtask

  task automatic test_blank_word();
    int validSeen;
    temp_word = HEBLO;
    rec_ready = 1'b1;
    tick();
    nChecks++;
    if (word_err !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL blank_word_err: got %b, need 1", word_err);
    end
    validSeen = (tx_valid === 1'b1) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (tx_valid === 1'b1 || busy === 1'b1) validSeen++;
    end
    nChecks++;
    if (validSeen != 0 || word_err !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL blank_no_tx: got %0d valid cycles err=%b, need 0 and err=1", validSeen, word_err);
    end
    rec_ready = 1'b0;
    tick();
    nChecks++;
    if (word_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL blank_clear: got word_err=%b, need 0", word_err);
    end
    tick();
  endtask

  task automatic test_game_end();
    int strays;
    logic [7:0] e;
    logic [7:0] o;
    temp_word = HELLO;
    tx_ready = 1'b1;
    rec_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    nChecks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4C) begin
      nFails++;
      $display("[TB] FAIL abort_pre_byte: got valid=%b data=%h, need 1 and 4c", tx_valid, tx_data);
    end
    tick();
    gameEnd_host = 1'b1;
    tick();
    gameEnd_host = 1'b0;
    nChecks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || send_done !== 1'b0 || word_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL abort_outputs: got valid=%b busy=%b done=%b err=%b, need all 0",
               tx_valid, busy, send_done, word_err);
    end
    strays = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (tx_valid === 1'b1 || send_done === 1'b1) strays++;
    end
    nChecks++;
    if (strays != 0) begin
      nFails++;
      $display("[TB] FAIL abort_no_resend: got %0d active cycles, need 0", strays);
    end
    rec_ready = 1'b0;
    tick();
    pushFrame(HELLO, 8'h42);
    rec_ready = 1'b1;
    captureFrame(99, 0, 1'b0, '0, 16);
    nChecks++;
    if (validCycles != 8 || doneCount != 1) begin
      nFails++;
      $display("[TB] FAIL abort_resend: got %0d valid %0d done, need 8 and 1", validCycles, doneCount);
    end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 8'hXX;
      nChecks++;
      if (o !== e) begin
        nFails++;
        $display("[TB] FAIL resend_byte: got %h, need %h", o, e);
      end
    end
  endtask

  task automatic test_hold_and_latch();
    int strays;
    logic [7:0] e;
    logic [7:0] o;
    temp_word = WORDS;
    pushFrame(WORDS, modelChk(WORDS));
    rec_ready = 1'b1;
    captureFrame(99, 0, 1'b1, HELLO, 16);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = (obsQ.size() > 0) ? obsQ.pop_front() : 8'hXX;
      nChecks++;
      if (o !== e) begin
        nFails++;
        $display("[TB] FAIL latch_byte: got %h, need %h", o, e);
      end
    end
    strays = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_valid === 1'b1 || send_done === 1'b1) strays++;
    end
    nChecks++;
    if (strays != 0) begin
      nFails++;
      $display("[TB] FAIL hold_no_resend: got %0d active cycles, need 0", strays);
    end
    rec_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    temp_word = HELLO;
    rec_ready = 1'b1;
    tick();
    tick();
    tick();
    nChecks++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL midreset_pre: got valid=%b busy=%b, need 1 and 1", tx_valid, busy);
    end
    #2;
    nRst = 1'b0;
    #1;
    nChecks++;
    if ({tx_valid, tx_data, busy, send_done, word_err} !== 12'h000) begin
      nFails++;
      $display("[TB] FAIL midreset_outputs: got valid=%b data=%h busy=%b done=%b err=%b, need all 0",
               tx_valid, tx_data, busy, send_done, word_err);
    end
    rec_ready = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
    tick();
    nChecks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_after: got valid=%b busy=%b, need 0 and 0", tx_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    releaseRec();
    test_stall();
    releaseRec();
    test_blank_word();
    test_game_end();
    releaseRec();
    test_hold_and_latch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
